// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between three burst requesters.
// Read data is passed straight through; a per-requester valid strobe marks it one cycle later.
module mem_port_arbiter #(
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 8,
    parameter int unsigned MAXB = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [2:0]      last,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic [1:0]      owner,
    output logic            busy,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [2:0]  rvalid_q, rvalid_d;

    logic [2:0]    own_oh;
    logic          own_req;
    logic          own_we;
    logic          own_last;
    logic          beat;
    logic          others_waiting;
    logic          cnt_hit;
    logic          burst_end;
    logic [1:0]    search_start;
    logic [2:0]    arb;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Returns {found, index} of the first set request searching start, start+1, start+2 (mod 3).
    function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] start);
        logic [1:0] c;
        logic       found;
        logic [1:0] win;
        c     = start;
        found = 1'b0;
        win   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!found && r[c]) begin
                found = 1'b1;
                win   = c;
            end
            c = inc3(c);
        end
        return {found, win};
    endfunction

    always_comb begin
        own_oh         = (state_q == StOwn) ? (3'b001 << owner_q) : 3'b000;
        own_req        = |(req & own_oh);
        own_we         = |(we & own_oh);
        own_last       = |(last & own_oh);
        beat           = own_req;
        others_waiting = |(req & ~own_oh);
        cnt_hit        = ({1'b0, beat_cnt_q} + 9'd1) == 9'(MAXB);
        // A granted cycle without req is a release even when last is also high.
        burst_end      = (state_q == StOwn) &&
                         (!own_req || own_last || (cnt_hit && others_waiting));
        search_start   = (state_q == StOwn) ? inc3(owner_q) : ptr_q;
        arb            = pick(req, search_start);
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        case (owner_q)
            2'd0: begin
                sel_addr  = addr[0*AW +: AW];
                sel_wdata = wdata[0*DW +: DW];
            end
            2'd1: begin
                sel_addr  = addr[1*AW +: AW];
                sel_wdata = wdata[1*DW +: DW];
            end
            2'd2: begin
                sel_addr  = addr[2*AW +: AW];
                sel_wdata = wdata[2*DW +: DW];
            end
            default: begin
                sel_addr  = '0;
                sel_wdata = '0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        rvalid_d   = 3'b000;

        if (beat && (beat_cnt_q != 8'hFF)) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end

        if (burst_end) begin
            ptr_d = inc3(owner_q);
        end

        if ((state_q == StIdle) || burst_end) begin
            if (arb[2]) begin
                state_d    = StOwn;
                owner_d    = arb[1:0];
                beat_cnt_d = 8'd0;
            end else begin
                state_d    = StIdle;
                owner_d    = 2'd3;
            end
        end

        // Strobe follows the requester that issued the read, even across a handover.
        if (beat && !own_we) begin
            rvalid_d = own_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= 2'd3;
            ptr_q      <= 2'd0;
            beat_cnt_q <= 8'd0;
            rvalid_q   <= 3'b000;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    always_comb begin
        gnt       = own_oh;
        owner     = owner_q;
        busy      = |own_oh;
        rvalid    = rvalid_q;
        rdata     = mem_rdata;
        mem_en    = beat;
        mem_we    = beat & own_we;
        mem_addr  = beat ? sel_addr : '0;
        mem_wdata = beat ? sel_wdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a small behavioural RAM model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req = '0;
    logic [2:0]      we = '0;
    logic [2:0]      last = '0;
    logic [3*AW-1:0] addr = '0;
    logic [3*DW-1:0] wdata = '0;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic [1:0]      owner;
    logic            busy;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAXB(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .last      (last),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .owner     (owner),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back as address ^ 0xA5.
    logic [7:0]   ram [256];
    logic [255:0] wr_mask = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                wr_mask[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_mask[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'hA5);
            end
        end
    end

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] we;
        logic [2:0] last;
        logic [7:0] a;
        logic [7:0] d;
        logic [2:0] gnt;
        logic [1:0] own;
        logic       en;
        logic       mwe;
        logic [7:0] ma;
        logic [7:0] md;
        logic [2:0] rv;
        logic [7:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] w,
                                input logic [2:0] l, input logic [7:0] a, input logic [7:0] d,
                                input logic [2:0] g, input logic [1:0] o, input logic en,
                                input logic mwe, input logic [7:0] ma, input logic [7:0] md,
                                input logic [2:0] rv, input logic [7:0] rd);
        vec_t v;
        v.rst = r;  v.req = rq; v.we = w;   v.last = l; v.a = a;   v.d = d;  v.gnt = g;
        v.own = o;  v.en = en;  v.mwe = mwe; v.ma = ma; v.md = md; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Requester i sees address a + 0x40*i and data d + 0x40*i.
    task automatic drive(input logic [2:0] rq, input logic [2:0] w, input logic [2:0] l,
                         input logic [7:0] a, input logic [7:0] d);
        logic [7:0] a1, a2, d1, d2;
        a1 = a + 8'h40; a2 = a + 8'h80;
        d1 = d + 8'h40; d2 = d + 8'h80;
        req = rq; we = w; last = l;
        addr  = {a2, a1, a};
        wdata = {d2, d1, d};
    endtask

    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        rst = v.rst;
        drive(v.req, v.we, v.last, v.a, v.d);
        #1;
        check(nm, {5'd0, gnt, owner, busy, mem_en, mem_we, mem_addr, mem_wdata, rvalid},
              {5'd0, v.gnt, v.own, |v.gnt, v.en, v.mwe, v.ma, v.md, v.rv});
        if (v.rv != 3'b000) check({nm, ".rdata"}, {24'd0, rdata}, {24'd0, v.rd});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(3'b000, 3'b000, 3'b000, 8'h00, 8'h00);
        @(posedge clk);
    endtask

    vec_t tbl [24];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   beats;
        logic seen;
        logic done;
        logic [2:0] hand;

        //               rst req    we     last   a     d      gnt    o  en mwe ma    md     rv     rd
        tbl[0]  = mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);
        tbl[1]  = mk(1'b0, 3'b001, 3'b001, 3'b000, 8'h00, 8'h11, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);
        tbl[2]  = mk(1'b0, 3'b001, 3'b001, 3'b000, 8'h00, 8'h11, 3'b001, 0, 1, 1, 8'h00, 8'h11, 3'b000, 8'h00);
        tbl[3]  = mk(1'b0, 3'b001, 3'b001, 3'b000, 8'h01, 8'h12, 3'b001, 0, 1, 1, 8'h01, 8'h12, 3'b000, 8'h00);
        tbl[4]  = mk(1'b0, 3'b001, 3'b001, 3'b000, 8'h02, 8'h13, 3'b001, 0, 1, 1, 8'h02, 8'h13, 3'b000, 8'h00);
        tbl[5]  = mk(1'b0, 3'b001, 3'b001, 3'b001, 8'h03, 8'h14, 3'b001, 0, 1, 1, 8'h03, 8'h14, 3'b000, 8'h00);
        tbl[6]  = mk(1'b0, 3'b001, 3'b000, 3'b001, 8'h02, 8'h00, 3'b001, 0, 1, 0, 8'h02, 8'h00, 3'b000, 8'h00);
        tbl[7]  = mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b001, 0, 0, 0, 8'h00, 8'h00, 3'b001, 8'h13);
        tbl[8]  = mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);
        tbl[9]  = mk(1'b1, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);
        tbl[10] = mk(1'b0, 3'b111, 3'b111, 3'b000, 8'h10, 8'h20, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);
        tbl[11] = mk(1'b0, 3'b111, 3'b111, 3'b000, 8'h10, 8'h20, 3'b001, 0, 1, 1, 8'h10, 8'h20, 3'b000, 8'h00);
        tbl[12] = mk(1'b0, 3'b111, 3'b111, 3'b001, 8'h11, 8'h21, 3'b001, 0, 1, 1, 8'h11, 8'h21, 3'b000, 8'h00);
        tbl[13] = mk(1'b0, 3'b111, 3'b111, 3'b000, 8'h10, 8'h22, 3'b010, 1, 1, 1, 8'h50, 8'h62, 3'b000, 8'h00);
        tbl[14] = mk(1'b0, 3'b111, 3'b111, 3'b010, 8'h11, 8'h23, 3'b010, 1, 1, 1, 8'h51, 8'h63, 3'b000, 8'h00);
        tbl[15] = mk(1'b0, 3'b101, 3'b111, 3'b000, 8'h10, 8'h24, 3'b100, 2, 1, 1, 8'h90, 8'hA4, 3'b000, 8'h00);
        tbl[16] = mk(1'b0, 3'b101, 3'b111, 3'b100, 8'h11, 8'h25, 3'b100, 2, 1, 1, 8'h91, 8'hA5, 3'b000, 8'h00);
        tbl[17] = mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b001, 0, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);
        tbl[18] = mk(1'b0, 3'b110, 3'b110, 3'b000, 8'h30, 8'h40, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);
        tbl[19] = mk(1'b0, 3'b110, 3'b110, 3'b000, 8'h30, 8'h40, 3'b010, 1, 1, 1, 8'h70, 8'h80, 3'b000, 8'h00);
        tbl[20] = mk(1'b0, 3'b100, 3'b110, 3'b010, 8'h31, 8'h41, 3'b010, 1, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);
        tbl[21] = mk(1'b0, 3'b100, 3'b110, 3'b100, 8'h31, 8'h41, 3'b100, 2, 1, 1, 8'hB1, 8'hC1, 3'b000, 8'h00);
        tbl[22] = mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b100, 2, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);
        tbl[23] = mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00);

        do_reset();
        for (int i = 0; i < 24; i++) step(tbl[i], $sformatf("tbl[%0d]", i));

        // Forced release at 16 beats while requester 2 waits, then requester 1 alone runs past it.
        do_reset();
        beats = 0; seen = 1'b0; done = 1'b0; hand = 3'b000;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            rst = 1'b0;
            drive(3'b110, 3'b110, 3'b000, 8'h20, 8'h30);
            #1;
            if (gnt == 3'b010) begin
                seen = 1'b1;
                if (mem_en) beats++;
            end else if (seen) begin
                hand = gnt;
                done = 1'b1;
            end
        end
        check("maxb_beats", beats, 16);
        check("maxb_handover", {29'd0, hand}, {29'd0, 3'b100});
        @(negedge clk);
        drive(3'b010, 3'b010, 3'b000, 8'h20, 8'h30);
        #1;
        check("rel2_no_beat", {28'd0, gnt, mem_en}, {28'd0, 3'b100, 1'b0});
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(3'b010, 3'b010, 3'b000, 8'h20, 8'h30);
            #1;
            if (gnt == 3'b010 && mem_en) beats++;
        end
        check("solo_beats", beats, 20);

        // Read in requester 2's final beat while ownership moves to requester 0.
        do_reset();
        step(mk(1'b0, 3'b100, 3'b100, 3'b000, 8'h05, 8'h5A, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00), "h1");
        step(mk(1'b0, 3'b100, 3'b100, 3'b000, 8'h05, 8'h5A, 3'b100, 2, 1, 1, 8'h85, 8'hDA, 3'b000, 8'h00), "h2");
        step(mk(1'b0, 3'b101, 3'b000, 3'b100, 8'h05, 8'h00, 3'b100, 2, 1, 0, 8'h85, 8'h80, 3'b000, 8'h00), "h3");
        step(mk(1'b0, 3'b001, 3'b000, 3'b001, 8'h07, 8'h00, 3'b001, 0, 1, 0, 8'h07, 8'h00, 3'b100, 8'hDA), "h4");
        step(mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b001, 0, 0, 0, 8'h00, 8'h00, 3'b001, 8'hA2), "h5");
        step(mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00), "h6");

        // Reset during a read beat; pending strobe suppressed, then 1 beats 2 with ptr back at 0.
        do_reset();
        step(mk(1'b0, 3'b001, 3'b000, 3'b000, 8'h04, 8'h00, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00), "r1");
        step(mk(1'b0, 3'b001, 3'b000, 3'b000, 8'h04, 8'h00, 3'b001, 0, 1, 0, 8'h04, 8'h00, 3'b000, 8'h00), "r2");
        step(mk(1'b1, 3'b001, 3'b000, 3'b000, 8'h05, 8'h00, 3'b001, 0, 1, 0, 8'h05, 8'h00, 3'b001, 8'hA1), "r3");
        step(mk(1'b0, 3'b110, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00), "r4");
        step(mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b010, 1, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00), "r5");
        step(mk(1'b0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00), "r6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
